xm_cex_decode_stage: RTL
========================

# xm_cex_decode_stage

Registered decode stage for the X-Makina 16-bit core. It classifies each fetched instruction into an operation code and tracks Conditional Execution (CEX) blocks across successive instructions. It then tags every instruction it passes downstream with an execute/suppress qualifier. It sits between the fetch register and the combinational field decoder/execute stage, with a valid/stall handshake on each side.

## Interface
- WORD, 16, instruction and datapath width (must be ≥ 16)
- CNT_W, 3, width of the CEX TC/FC count fields, giving a maximum block length of 2^CNT_W−1 per side
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset: one clock; reset is synchronous and active-high
- valid_i  in  1  inst_i holds a fetched instruction
- inst_i  in  WORD  fetched instruction
- flags_i  in  4  PSW flags {V,N,Z,C} = bits {3,2,1,0}
- stall_i  in  1  downstream cannot accept this cycle
- flush_i  in  1  pipeline redirect (taken branch, trap)
- ready_o  out  1  stage accepts inst_i this cycle
- valid_o  out  1  output registers hold an instruction
- inst_o  out  WORD  registered instruction
- instOp_o  out  5  operation class
- exec_o  out  1  1 = instruction takes architectural effect; 0 = treat as no-op
- cexActive_o  out  1  output instruction lies inside a CEX block

## Operation
- instOp encoding:
  - RES_OP0=0, RES_OP1=1, COND_BRANCH=2, LINK_BRANCH=3, ALU=4, ACC_LOAD=5, ACC_STORE=6, REL_LOAD=7, REL_STORE=8, IMM_LOAD=9, SWAP=10, TRAP_CALL=11, COND_EXEC=12, BREAK=13.
- Opcode map:
  - [15:13]=000 → LINK_BRANCH; 001 → COND_BRANCH.
  - [15:12]=0100: SWAP if [11:8]=1100, otherwise ALU.
  - [15:12]=0101: [11:10]=00 ACC_LOAD, 01 ACC_STORE, 10 TRAP_CALL, 11 COND_EXEC.
  - [15:13]=011 → IMM_LOAD; [15:14]=10 → REL_LOAD; 11 → REL_STORE.
- CEX fields:
  - cond = inst[8:6], with codes EQ=0 NE=1 HS=2 LO=3 N=4 GE=5 LT=6 AL=7 (EQ:Z, NE:!Z, HS:C, LO:!C, N:N, GE:!(N^V), LT:N^V, AL:1).
  - TC = inst[2*CNT_W-1:CNT_W], FC = inst[CNT_W-1:0].
  - inst[9] is ignored.
- Accept condition: valid_i && ready_o. ready_o = !valid_o || !stall_i.
- FSM states: IDLE, TRUE_BLK, FALSE_BLK. Internal registers: tCnt, fCnt (CNT_W bits each) and condRes.
- IDLE:
  - A non-CEX instruction passes with exec_o=1 and cexActive_o=0.
  - An accepted CEX latches condRes from flags_i in the same cycle, and sets tCnt=TC, fCnt=FC. The next state is TRUE_BLK if TC≠0, else FALSE_BLK if FC≠0, else IDLE.
- TRUE_BLK: each accepted instruction gets exec_o=condRes and cexActive_o=1, then tCnt decrements. When tCnt reaches 0, the next state is FALSE_BLK if fCnt≠0, else IDLE.
- FALSE_BLK: each accepted instruction gets exec_o=!condRes and cexActive_o=1, then fCnt decrements. When fCnt reaches 0, the next state is IDLE.
- A CEX instruction itself always leaves with exec_o=0, instOp_o=COND_EXEC.
- Nested CEX (a CEX accepted inside a block) is not a new block:
  - It counts as one block slot, with exec_o=0.
  - Its fields are ignored.
- Condition is sampled once, at CEX acceptance. Flag changes from instructions inside the block do not re-evaluate it.
- flush_i has highest priority and overrides stall_i:
  - Next cycle: valid_o=0, state=IDLE, counters=0.
  - Any instruction presented in the flush cycle is dropped.
- Stall: valid_o && stall_i holds every output register and all FSM state unchanged.

## Timing
- Latency: 1 cycle. An instruction accepted at edge n appears on the outputs after edge n, together with its exec_o and cexActive_o.
- FSM and counter updates happen only on accept edges. Cycles with no accept leave the block state frozen.
- Full throughput: one instruction per cycle when stall_i=0.
- Reset values: valid_o=0, inst_o=0, instOp_o=0, exec_o=0, cexActive_o=0, state=IDLE, tCnt=fCnt=0, condRes=0.
- ready_o is combinational from valid_o and stall_i, so it is 1 immediately after reset.
- Reset asserted mid-block abandons the block. The next instruction after release executes unconditionally.

## Test plan
- Reset with valid_i=1, inst_i=16'h4000 → valid_o=0, ready_o=1 during reset. After release, the next edge gives instOp_o=4, exec_o=1.
- Z=1; stream 5C11 (CEX EQ TC2 FC1), 4000, 4000, 4000, 4000:
  - exec_o = 0,1,1,0,1.
  - cexActive_o = 0,1,1,1,0.
- Z=0; same stream → exec_o = 0,0,0,1,1.
- Z=1; stream 5C11, then stall_i=1 for 3 cycles after the first block instruction:
  - Outputs hold during the stall.
  - After release, the block resumes with exec_o = 1,0 and then 1 for the post-block instruction.
- Z=1; stream 5C11, 4000, then flush_i together with a second 4000:
  - Next cycle valid_o=0.
  - The following 4000 gives exec_o=1, cexActive_o=0.
- Z=0; stream 5C49 (CEX NE TC1 FC1), 5C11, 4000, 4000:
  - exec_o = 0,0,0,1.
  - The inner CEX consumes the TC slot.
  - The final 4000 runs with cexActive_o=0.

Source files
------------

// File: rtl/xm_cex_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : xm_cex_decode_stage
// Purpose  : Registered decode stage for the X-Makina 16-bit core. Classifies
//            each fetched instruction into an operation class and tracks
//            Conditional Execution (CEX) blocks, tagging every outgoing
//            instruction with an execute/suppress qualifier.
// Ports    : clk_i, rst_i      - clock, synchronous active-high reset
//            valid_i, inst_i   - fetched instruction and its valid
//            flags_i           - PSW flags {V,N,Z,C}
//            stall_i, flush_i  - downstream back-pressure, pipeline redirect
//            ready_o           - stage accepts inst_i this cycle
//            valid_o, inst_o   - registered instruction and its valid
//            instOp_o          - operation class
//            exec_o            - 1 = takes architectural effect, 0 = no-op
//            cexActive_o       - output instruction lies inside a CEX block
// Revision : 1.0 - initial release
// ============================================================================
module xm_cex_decode_stage #(
    parameter int WORD  = 16,
    parameter int CNT_W = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [WORD-1:0] inst_i,
    input  logic [3:0]      flags_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [WORD-1:0] inst_o,
    output logic [4:0]      instOp_o,
    output logic            exec_o,
    output logic            cexActive_o
);

    // Operation classes
    localparam logic [4:0] c_OP_RES0        = 5'd0;
    localparam logic [4:0] c_OP_COND_BRANCH = 5'd2;
    localparam logic [4:0] c_OP_LINK_BRANCH = 5'd3;
    localparam logic [4:0] c_OP_ALU         = 5'd4;
    localparam logic [4:0] c_OP_ACC_LOAD    = 5'd5;
    localparam logic [4:0] c_OP_ACC_STORE   = 5'd6;
    localparam logic [4:0] c_OP_REL_LOAD    = 5'd7;
    localparam logic [4:0] c_OP_REL_STORE   = 5'd8;
    localparam logic [4:0] c_OP_IMM_LOAD    = 5'd9;
    localparam logic [4:0] c_OP_SWAP        = 5'd10;
    localparam logic [4:0] c_OP_TRAP_CALL   = 5'd11;
    localparam logic [4:0] c_OP_COND_EXEC   = 5'd12;

    // Block-tracking states
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_TRUE_BLK  = 2'd1;
    localparam logic [1:0] c_ST_FALSE_BLK = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_tcnt;
    logic [CNT_W-1:0] r_fcnt;
    logic             r_cond_res;

    logic             r_valid;
    logic [WORD-1:0]  r_inst;
    logic [4:0]       r_op;
    logic             r_exec;
    logic             r_cex_active;

    logic [4:0]       w_op;
    logic             w_is_cex;
    logic             w_cond;
    logic             w_ready;
    logic             w_accept;
    logic [CNT_W-1:0] w_tc;
    logic [CNT_W-1:0] w_fc;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_tcnt_nxt;
    logic [CNT_W-1:0] w_fcnt_nxt;
    logic             w_cond_nxt;
    logic             w_exec;
    logic             w_cex_active;

    assign w_ready  = !r_valid || !stall_i;
    assign w_accept = valid_i && w_ready;
    assign w_is_cex = (w_op == c_OP_COND_EXEC);
    assign w_tc     = inst_i[2*CNT_W-1:CNT_W];
    assign w_fc     = inst_i[CNT_W-1:0];

    // Opcode classification
    always_comb begin
        w_op = c_OP_RES0;
        casez (inst_i[15:12])
            4'b000?: w_op = c_OP_LINK_BRANCH;
            4'b001?: w_op = c_OP_COND_BRANCH;
            4'b0100: w_op = (inst_i[11:8] == 4'b1100) ? c_OP_SWAP : c_OP_ALU;
            4'b0101: begin
                case (inst_i[11:10])
                    2'b00:   w_op = c_OP_ACC_LOAD;
                    2'b01:   w_op = c_OP_ACC_STORE;
                    2'b10:   w_op = c_OP_TRAP_CALL;
                    default: w_op = c_OP_COND_EXEC;
                endcase
            end
            4'b011?: w_op = c_OP_IMM_LOAD;
            4'b10??: w_op = c_OP_REL_LOAD;
            4'b11??: w_op = c_OP_REL_STORE;
            default: w_op = c_OP_RES0;
        endcase
    end

    // CEX condition against the flags present at acceptance: {V,N,Z,C}
    always_comb begin
        w_cond = 1'b1;
        case (inst_i[8:6])
            3'd0:    w_cond = flags_i[1];
            3'd1:    w_cond = !flags_i[1];
            3'd2:    w_cond = flags_i[0];
            3'd3:    w_cond = !flags_i[0];
            3'd4:    w_cond = flags_i[2];
            3'd5:    w_cond = !(flags_i[2] ^ flags_i[3]);
            3'd6:    w_cond = flags_i[2] ^ flags_i[3];
            default: w_cond = 1'b1;
        endcase
    end

    // Next block state and the qualifier for the instruction being accepted.
    // A CEX seen inside a block is just another slot: it never reloads fields.
    always_comb begin
        w_state_nxt  = r_state;
        w_tcnt_nxt   = r_tcnt;
        w_fcnt_nxt   = r_fcnt;
        w_cond_nxt   = r_cond_res;
        w_exec       = 1'b1;
        w_cex_active = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_is_cex) begin
                    w_exec     = 1'b0;
                    w_cond_nxt = w_cond;
                    w_tcnt_nxt = w_tc;
                    w_fcnt_nxt = w_fc;
                    if (w_tc != '0)
                        w_state_nxt = c_ST_TRUE_BLK;
                    else if (w_fc != '0)
                        w_state_nxt = c_ST_FALSE_BLK;
                    else
                        w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_TRUE_BLK: begin
                w_exec       = !w_is_cex && r_cond_res;
                w_cex_active = 1'b1;
                w_tcnt_nxt   = r_tcnt - c_CNT_ONE;
                if (r_tcnt == c_CNT_ONE)
                    w_state_nxt = (r_fcnt != '0) ? c_ST_FALSE_BLK : c_ST_IDLE;
            end
            c_ST_FALSE_BLK: begin
                w_exec       = !w_is_cex && !r_cond_res;
                w_cex_active = 1'b1;
                w_fcnt_nxt   = r_fcnt - c_CNT_ONE;
                if (r_fcnt == c_CNT_ONE)
                    w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Block state advances only on accept edges; flush wins over everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_IDLE;
            r_tcnt     <= '0;
            r_fcnt     <= '0;
            r_cond_res <= 1'b0;
        end else if (flush_i) begin
            r_state <= c_ST_IDLE;
            r_tcnt  <= '0;
            r_fcnt  <= '0;
        end else if (w_accept) begin
            r_state    <= w_state_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_fcnt     <= w_fcnt_nxt;
            r_cond_res <= w_cond_nxt;
        end
    end

    // Output registers: load on accept, drain when not stalled, else hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid      <= 1'b0;
            r_inst       <= '0;
            r_op         <= '0;
            r_exec       <= 1'b0;
            r_cex_active <= 1'b0;
        end else if (flush_i) begin
            r_valid      <= 1'b0;
            r_exec       <= 1'b0;
            r_cex_active <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_inst       <= inst_i;
            r_op         <= w_op;
            r_exec       <= w_exec;
            r_cex_active <= w_cex_active;
        end else if (w_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign ready_o     = w_ready;
    assign valid_o     = r_valid;
    assign inst_o      = r_inst;
    assign instOp_o    = r_op;
    assign exec_o      = r_exec;
    assign cexActive_o = r_cex_active;

endmodule
`default_nettype wire
